// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared fetch-stage types and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int DEFAULT_WORDSIZE         = 64;
    localparam int DEFAULT_INSTRUCTION_SIZE = 32;
    localparam int INSTR_BYTES              = 4;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : PC register, instruction capture and valid/ready hand-off to
//               decode. Optional macro INSTRUCTION_FETCH_COUNT_EN adds a
//               32-bit handshake counter output fetch_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int WORDSIZE         = DEFAULT_WORDSIZE,
    parameter int INSTRUCTION_SIZE = DEFAULT_INSTRUCTION_SIZE,
    parameter int MEMORY_SIZE      = 1024,
    parameter int RESET_PC         = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [WORDSIZE-1:0]         imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
    input  logic                        redirect_valid,
    input  logic [WORDSIZE-1:0]         redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTION_SIZE-1:0] out_instruction,
    output logic [WORDSIZE-1:0]         out_pc,
    output logic                        halted,
    output logic                        misaligned
`ifdef INSTRUCTION_FETCH_COUNT_EN
    ,
    output logic [31:0]                 fetch_count
`endif
);

    localparam logic [WORDSIZE-3:0] c_mem_words = (WORDSIZE-2)'(MEMORY_SIZE);
    localparam logic [WORDSIZE-1:0] c_reset_pc  = WORDSIZE'(RESET_PC);
    localparam logic [WORDSIZE-1:0] c_step      = WORDSIZE'(INSTR_BYTES);

    logic [WORDSIZE-1:0] r_pc;
    fetch_state_t        r_state;
    logic                w_in_range;
    logic                w_advance;

    assign imem_addr  = {2'b00, r_pc[WORDSIZE-1:2]};
    assign w_in_range = (r_pc[WORDSIZE-1:2] < c_mem_words);
    assign w_advance  = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= c_reset_pc;
            r_state         <= RUN;
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_pc          <= '0;
            halted          <= 1'b0;
            misaligned      <= 1'b0;
        end else if (redirect_valid) begin
            // A redirect flushes whatever is held, even if decode is stalled.
            out_valid <= 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
                r_pc       <= redirect_pc;
                misaligned <= 1'b0;
                halted     <= 1'b0;
                r_state    <= RUN;
            end else begin
                misaligned <= 1'b1;
                halted     <= 1'b1;
                r_state    <= HALT;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (!w_in_range) begin
                        r_state <= HALT;
                        halted  <= 1'b1;
                        if (out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end else if (w_advance) begin
                        out_instruction <= imem_instruction;
                        out_pc          <= r_pc;
                        out_valid       <= 1'b1;
                        r_pc            <= r_pc + c_step;
                    end
                end
                HALT: begin
                    // An instruction captured before halting still drains.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= HALT;
                    halted  <= 1'b1;
                end
            endcase
        end
    end

`ifdef INSTRUCTION_FETCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (out_valid && out_ready) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule : instruction_fetch

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Scoreboard bench for instruction_fetch plus a small-memory
//               instance for the end-of-memory halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready_a = 1'b1;
    logic        ready_b = 1'b1;
    logic        redir_valid = 1'b0;
    logic [63:0] redir_pc = '0;

    logic [63:0] addr_a, addr_b, pc_a, pc_b;
    logic [31:0] imem_a, imem_b, instr_a, instr_b;
    logic        valid_a, valid_b, halted_a, halted_b, mis_a, mis_b;
`ifdef INSTRUCTION_FETCH_COUNT_EN
    logic [31:0] fc_a, fc_b;
`endif

    logic [31:0] mem [0:1023];
    logic [95:0] expq [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    assign imem_a = (addr_a < 64'd1024) ? mem[addr_a[9:0]] : 32'h0;
    assign imem_b = (addr_b < 64'd1024) ? mem[addr_b[9:0]] : 32'h0;

    instruction_fetch #(.MEMORY_SIZE(1024), .RESET_PC(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr_a), .imem_instruction(imem_a),
        .redirect_valid(redir_valid), .redirect_pc(redir_pc),
        .out_valid(valid_a), .out_ready(ready_a), .out_instruction(instr_a),
        .out_pc(pc_a), .halted(halted_a), .misaligned(mis_a)
`ifdef INSTRUCTION_FETCH_COUNT_EN
        , .fetch_count(fc_a)
`endif
    );

    instruction_fetch #(.MEMORY_SIZE(16), .RESET_PC(60)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr_b), .imem_instruction(imem_b),
        .redirect_valid(1'b0), .redirect_pc(64'h0),
        .out_valid(valid_b), .out_ready(ready_b), .out_instruction(instr_b),
        .out_pc(pc_b), .halted(halted_b), .misaligned(mis_b)
`ifdef INSTRUCTION_FETCH_COUNT_EN
        , .fetch_count(fc_b)
`endif
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] ins);
        expq.push_back({pc, ins});
    endtask

    // Monitor: every presented-and-accepted pair must match the queue head.
    always @(negedge clk) begin
        if (rst_n && valid_a && ready_a) begin
            if (expq.size() == 0) begin
                check("unexpected_output", {pc_a, instr_a}, 96'h0);
            end else begin
                check("handshake_pair", {pc_a, instr_a}, expq.pop_front());
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1300_0000 + i;
        mem[0] = 32'h06B38183;
        mem[1] = 32'h6A79A1A3;
        mem[2] = 32'h007981B3;
        mem[3] = 32'h41FC8333;

        // Reset state
        repeat (2) tick();
        check("rst_valid",  {95'h0, valid_a},  96'h0);
        check("rst_instr",  {64'h0, instr_a},  96'h0);
        check("rst_pc",     {32'h0, pc_a},     96'h0);
        check("rst_flags",  {94'h0, halted_a, mis_a}, 96'h0);

        // Streaming with out_ready high, then async reset mid-stream
        push(64'd0,  32'h06B38183);
        push(64'd4,  32'h6A79A1A3);
        push(64'd8,  32'h007981B3);
        push(64'd12, 32'h41FC8333);
        rst_n = 1'b1;
        tick();
        check("valid_after_release", {95'h0, valid_a}, 96'h1);
        check("b_last_word", {valid_b, pc_b, instr_b}, {1'b1, 64'd60, 32'h1300_000F});
        tick();
        check("b_halt", {94'h0, valid_b, halted_b}, 96'h1);
        repeat (3) tick();
        check("b_stays_halted", {94'h0, valid_b, halted_b}, 96'h1);
`ifdef INSTRUCTION_FETCH_COUNT_EN
        check("fetch_count_4", {64'h0, fc_a}, 96'd4);
`endif
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {valid_a, pc_a, instr_a}, 96'h0);
`ifdef INSTRUCTION_FETCH_COUNT_EN
        check("fetch_count_rst", {64'h0, fc_a}, 96'd0);
`endif

        // Backpressure holding pc 4 for three cycles
        push(64'd0, 32'h06B38183);
        push(64'd4, 32'h6A79A1A3);
        push(64'd8, 32'h007981B3);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        ready_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_hold", {valid_a, pc_a, instr_a}, {1'b1, 64'd4, 32'h6A79A1A3});
            tick();
        end
        check("stall_hold_end", {valid_a, pc_a, instr_a}, {1'b1, 64'd4, 32'h6A79A1A3});
        ready_a = 1'b1;
        tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;

        // Redirect while pc 0 is held under backpressure
        ready_a = 1'b0;
        push(64'd8, 32'h007981B3);
        tick();
        rst_n = 1'b1;
        tick();
        check("held_pc0", {95'h0, valid_a}, 96'h1);
        redir_valid = 1'b1;
        redir_pc    = 64'h8;
        tick();
        redir_valid = 1'b0;
        check("redirect_bubble", {95'h0, valid_a}, 96'h0);
        tick();
        check("redirect_target", {valid_a, pc_a}, {31'h0, 1'b1, 64'd8});
        ready_a = 1'b1;
        tick();

        // Misaligned redirect halts; aligned redirect resumes
        ready_a     = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 64'h6;
        tick();
        redir_valid = 1'b0;
        ready_a     = 1'b1;
        check("misaligned_halt", {93'h0, mis_a, halted_a, valid_a}, 96'b110);
        repeat (2) tick();
        check("halt_no_fetch", {93'h0, mis_a, halted_a, valid_a}, 96'b110);
        push(64'd0, 32'h06B38183);
        push(64'd4, 32'h6A79A1A3);
        redir_valid = 1'b1;
        redir_pc    = 64'h0;
        tick();
        redir_valid = 1'b0;
        check("resume_clear", {93'h0, mis_a, halted_a, valid_a}, 96'b000);
        tick();
        tick();
        @(negedge clk);
        #1;
        ready_a = 1'b0;
        repeat (3) tick();
        check("queue_drained", 96'(expq.size()), 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_instruction_fetch

`default_nettype wire
